// File: rtl/multi_clock_divider_if.sv
// -----------------------------------------------------------------------------
// multi_clock_divider_if
// Bundles the per-channel enables, the ratio-programming port and the divided
// clock outputs of multi_clock_divider.
//   en_i       per-channel run enable (level)
//   cfg_we_i   ratio write strobe
//   cfg_ch_i   channel index for the ratio write
//   cfg_div_i  requested ratio N (period = N clock cycles)
//   clk_out_o  divided clocks
//   tick_o     one-cycle pulse in the first cycle of every period
//   busy_o     channel is running
// The "master" modport drives enables/configuration; "slave" is the divider.
// -----------------------------------------------------------------------------
interface multi_clock_divider_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] en_i;
   logic              cfg_we_i;
   logic [CH_W-1:0]   cfg_ch_i;
   logic [CNT_W-1:0]  cfg_div_i;
   logic [NUM_CH-1:0] clk_out_o;
   logic [NUM_CH-1:0] tick_o;
   logic [NUM_CH-1:0] busy_o;

   modport master (
      output en_i, cfg_we_i, cfg_ch_i, cfg_div_i,
      input  clk_out_o, tick_o, busy_o
   );

   modport slave (
      input  en_i, cfg_we_i, cfg_ch_i, cfg_div_i,
      output clk_out_o, tick_o, busy_o
   );
endinterface

// File: rtl/multi_clock_divider.sv
// -----------------------------------------------------------------------------
// multi_clock_divider
// NUM_CH independent clock dividers running from one clock. Each channel has a
// programmable ratio register; the ratio actually used (active_div) is only
// reloaded at a period boundary, so reprogramming never produces a runt pulse.
// Dropping a channel's enable lets the current period finish before the
// output parks low.
// Ports:
//   clk_i   single clock, all logic on its rising edge
//   rst_i   synchronous active-high reset
//   bus     multi_clock_divider_if.slave (enables, ratio writes, outputs)
// Outputs clk_out_o, tick_o and busy_o are all driven straight from flops.
// -----------------------------------------------------------------------------
module multi_clock_divider #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input logic                  clk_i,
   input logic                  rst_i,
   multi_clock_divider_if.slave bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [CNT_W-1:0] DIV_MIN   = CNT_W'(32'd2);
   localparam logic [CNT_W-1:0] DIV_RESET = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                        state_r [NUM_CH];
   state_t                        state_s [NUM_CH];
   logic [NUM_CH-1:0][CNT_W-1:0]  div_reg_r;
   logic [NUM_CH-1:0][CNT_W-1:0]  div_reg_s;
   logic [NUM_CH-1:0][CNT_W-1:0]  active_div_r;
   logic [NUM_CH-1:0][CNT_W-1:0]  active_div_s;
   logic [NUM_CH-1:0][CNT_W-1:0]  cnt_r;
   logic [NUM_CH-1:0][CNT_W-1:0]  cnt_s;
   logic [NUM_CH-1:0][CNT_W:0]    cnt_inc_s;
   logic [NUM_CH-1:0][CNT_W-1:0]  half_s;
   logic [NUM_CH-1:0]             clk_out_r;
   logic [NUM_CH-1:0]             clk_out_s;
   logic [NUM_CH-1:0]             tick_r;
   logic [NUM_CH-1:0]             tick_s;
   logic [NUM_CH-1:0]             busy_r;
   logic [NUM_CH-1:0]             busy_s;

   // Ratios below 2 cannot form a high and a low phase, so they clamp to 2.
   function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] req);
      logic [CNT_W-1:0] res;
      if (req < DIV_MIN) begin
         res = DIV_MIN;
      end else begin
         res = req;
      end
      return res;
   endfunction

   // Ratio register update; an index with no matching channel writes nothing.
   always_comb begin
      div_reg_s = div_reg_r;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (bus.cfg_we_i && (bus.cfg_ch_i == CH_W'(ch))) begin
            div_reg_s[ch] = clamp_div(bus.cfg_div_i);
         end else begin
            div_reg_s[ch] = div_reg_r[ch];
         end
      end
   end

   // Per-channel next state: counter, active ratio and registered outputs.
   always_comb begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         state_s[ch]      = state_r[ch];
         cnt_s[ch]        = cnt_r[ch];
         active_div_s[ch] = active_div_r[ch];
         clk_out_s[ch]    = 1'b0;
         tick_s[ch]       = 1'b0;
         busy_s[ch]       = 1'b0;
         // High phase lasts floor(N/2) cycles; the output for the next
         // cycle is decided from the counter value it will hold then.
         cnt_inc_s[ch]    = {1'b0, cnt_r[ch]} + {1'b0, CNT_ONE};
         half_s[ch]       = active_div_r[ch] >> 1;

         case (state_r[ch])
            ST_IDLE: begin
               cnt_s[ch] = CNT_ZERO;
               if (bus.en_i[ch]) begin
                  state_s[ch]      = ST_RUN;
                  active_div_s[ch] = div_reg_r[ch];
                  clk_out_s[ch]    = 1'b1;
                  tick_s[ch]       = 1'b1;
                  busy_s[ch]       = 1'b1;
               end else begin
                  state_s[ch]      = ST_IDLE;
               end
            end
            ST_RUN: begin
               busy_s[ch] = 1'b1;
               if (cnt_r[ch] != (active_div_r[ch] - CNT_ONE)) begin
                  cnt_s[ch]     = cnt_inc_s[ch][CNT_W-1:0];
                  clk_out_s[ch] = (cnt_inc_s[ch] < {1'b0, half_s[ch]});
               end else if (bus.en_i[ch]) begin
                  // Boundary: the ratio register value from before any
                  // same-cycle write is what the new period uses.
                  cnt_s[ch]        = CNT_ZERO;
                  active_div_s[ch] = div_reg_r[ch];
                  clk_out_s[ch]    = 1'b1;
                  tick_s[ch]       = 1'b1;
               end else begin
                  state_s[ch] = ST_IDLE;
                  cnt_s[ch]   = CNT_ZERO;
                  busy_s[ch]  = 1'b0;
               end
            end
            default: begin
               state_s[ch]      = ST_IDLE;
               cnt_s[ch]        = CNT_ZERO;
               active_div_s[ch] = div_reg_r[ch];
            end
         endcase
      end
   end

   // State, counter, ratio and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            state_r[ch] <= ST_IDLE;
         end
         div_reg_r    <= {NUM_CH{DIV_RESET}};
         active_div_r <= {NUM_CH{DIV_RESET}};
         cnt_r        <= {NUM_CH{CNT_ZERO}};
         clk_out_r    <= {NUM_CH{1'b0}};
         tick_r       <= {NUM_CH{1'b0}};
         busy_r       <= {NUM_CH{1'b0}};
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            state_r[ch] <= state_s[ch];
         end
         div_reg_r    <= div_reg_s;
         active_div_r <= active_div_s;
         cnt_r        <= cnt_s;
         clk_out_r    <= clk_out_s;
         tick_r       <= tick_s;
         busy_r       <= busy_s;
      end
   end

   assign bus.clk_out_o = clk_out_r;
   assign bus.tick_o    = tick_r;
   assign bus.busy_o    = busy_r;

   multi_clock_divider_chk #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) u_chk (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .div_reg    (div_reg_r),
      .active_div (active_div_r),
      .cnt        (cnt_r),
      .clk_out    (clk_out_r),
      .tick       (tick_r),
      .busy       (busy_r)
   );
endmodule

// -----------------------------------------------------------------------------
// multi_clock_divider_chk
// Invariants of every channel: counter stays inside the active period, ratios
// never drop below 2, ticks only occur on a running, high output, and an idle
// channel is fully parked.
// -----------------------------------------------------------------------------
module multi_clock_divider_chk #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input logic                         clk_i,
   input logic                         rst_i,
   input logic [NUM_CH-1:0][CNT_W-1:0] div_reg,
   input logic [NUM_CH-1:0][CNT_W-1:0] active_div,
   input logic [NUM_CH-1:0][CNT_W-1:0] cnt,
   input logic [NUM_CH-1:0]            clk_out,
   input logic [NUM_CH-1:0]            tick,
   input logic [NUM_CH-1:0]            busy
);
   localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(32'd2);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   // Per-channel invariant checks on the registered state.
   always @(posedge clk_i) begin
      if (!rst_i) begin
         for (int c = 0; c < NUM_CH; c++) begin
            assert (cnt[c] < active_div[c]);
            assert (active_div[c] >= DIV_MIN);
            assert (div_reg[c] >= DIV_MIN);
            assert (!tick[c] || (clk_out[c] && busy[c]));
            assert (busy[c] || (!clk_out[c] && (cnt[c] == CNT_ZERO)));
         end
      end
   end
endmodule
